// File: rtl/crtc.sv
// crtc: MC6845-compatible CRT controller producing character-cell timing for the EG2000 video path.
// Define CRTC_BLINK_EN to add the 5-bit field counter that drives cursor blink modes.
module crtc #(
  parameter int HC_W = 8,
  parameter int MA_W = 14
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cep,
  input  logic            cs,
  input  logic            rs,
  input  logic            wr,
  input  logic            rd,
  input  logic [7:0]      d,
  output logic [7:0]      q,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic            cursor,
  output logic [MA_W-1:0] vma,
  output logic [2:0]      vra
);
  logic [4:0] addrReg;
  logic [7:0] r0, r1, r2, r3, r13, r15;
  logic [6:0] r4, r6, r7, r10;
  logic [4:0] r5, r9, r11;
  logic [5:0] r12, r14;

  // CPU access: rs=0 loads the index, rs=1 writes the indexed register.
  // Valid/ready does not apply here: each wr pulse is one complete access.
  always_ff @(posedge clock) begin
    if (reset) begin
      addrReg <= '0;
      r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0; r5 <= '0;
      r6 <= '0; r7 <= '0; r9 <= '0; r10 <= '0; r11 <= '0; r12 <= '0;
      r13 <= '0; r14 <= '0; r15 <= '0;
    end else if (cs && wr) begin
      if (!rs) begin
        addrReg <= d[4:0];
      end else begin
        case (addrReg)
          5'd0:  r0  <= d;
          5'd1:  r1  <= d;
          5'd2:  r2  <= d;
          5'd3:  r3  <= d;
          5'd4:  r4  <= d[6:0];
          5'd5:  r5  <= d[4:0];
          5'd6:  r6  <= d[6:0];
          5'd7:  r7  <= d[6:0];
          5'd9:  r9  <= d[4:0];
          5'd10: r10 <= d[6:0];
          5'd11: r11 <= d[4:0];
          5'd12: r12 <= d[5:0];
          5'd13: r13 <= d;
          5'd14: r14 <= d[5:0];
          5'd15: r15 <= d;
          default: ;
        endcase
      end
    end
  end

  assign q = (cs && rd && rs && addrReg == 5'd14) ? {2'b00, r14} :
             (cs && rd && rs && addrReg == 5'd15) ? r15 : 8'h00;

  logic [HC_W-1:0] hTotal, hDisp, hsPos;
  logic [3:0]      hsWidth;
  logic [4:0]      vsWidth;
  logic [MA_W-1:0] startAddr, curAddr;

  assign hTotal    = HC_W'(r0);
  assign hDisp     = HC_W'(r1);
  assign hsPos     = HC_W'(r2);
  assign hsWidth   = r3[3:0];
  assign vsWidth   = {r3[7:4] == 4'd0, r3[7:4]};
  assign startAddr = MA_W'({r12, r13});
  assign curAddr   = MA_W'({r14, r15});

  logic [HC_W-1:0] hc;
  logic [4:0]      rc;
  logic [6:0]      vc;
  logic            inAdj;
  logic [MA_W-1:0] ls, addr;
  logic [3:0]      hsLeft;
  logic [4:0]      vsLeft;
`ifdef CRTC_BLINK_EN
  logic [4:0]      field;
`endif

  logic eol, rowEnd, adjStart, frameEnd, lsLoad, hsStart, vsStart, deNow, curNow, modeGate;
  logic [MA_W-1:0] lsNext;

  always_comb begin
    eol      = hc == hTotal;
    rowEnd   = eol && !inAdj && rc == r9;
    adjStart = rowEnd && vc == r4 && r5 != 5'd0;
    frameEnd = (rowEnd && vc == r4 && r5 == 5'd0) ||
               (eol && inAdj && rc == r5 - 5'd1);
    lsLoad   = hc == hDisp && rc == r9;
    lsNext   = frameEnd ? startAddr : (lsLoad ? addr : ls);
    hsStart  = hc == hsPos;
    vsStart  = hc == '0 && rc == 5'd0 && vc == r7 && !inAdj;
    deNow    = hc < hDisp && vc < r6 && !inAdj;
`ifdef CRTC_BLINK_EN
    case (r10[6:5])
      2'b00:   modeGate = 1'b1;
      2'b01:   modeGate = 1'b0;
      2'b10:   modeGate = field[3];
      default: modeGate = field[4];
    endcase
`else
    modeGate = r10[6:5] != 2'b01;
`endif
    curNow   = deNow && addr == curAddr && rc >= r10[4:0] && rc <= r11 && modeGate;
  end

  // Outputs register the decode of the current position, so they trail the counters by one cep.
  always_ff @(posedge clock) begin
    if (reset) begin
      hc <= '0; rc <= '0; vc <= '0; inAdj <= 1'b0;
      ls <= '0; addr <= '0; hsLeft <= '0; vsLeft <= '0;
`ifdef CRTC_BLINK_EN
      field <= '0;
`endif
      hsync <= 1'b0; vsync <= 1'b0; de <= 1'b0; cursor <= 1'b0;
      vma <= '0; vra <= '0;
    end else if (cep) begin
      hc   <= eol ? '0 : hc + HC_W'(1);
      ls   <= lsNext;
      addr <= eol ? lsNext : addr + MA_W'(1);
      if (frameEnd) begin
        rc <= '0; vc <= '0; inAdj <= 1'b0;
`ifdef CRTC_BLINK_EN
        field <= field + 5'd1;
`endif
      end else if (adjStart) begin
        rc <= '0; inAdj <= 1'b1;
      end else if (rowEnd) begin
        rc <= '0; vc <= vc + 7'd1;
      end else if (eol) begin
        rc <= rc + 5'd1;
      end
      if (hsStart)
        hsLeft <= (hsWidth == 4'd0) ? 4'd0 : hsWidth - 4'd1;
      else if (hsLeft != 4'd0)
        hsLeft <= hsLeft - 4'd1;
      // vsLeft counts remaining whole lines; it drops at each end-of-line.
      if (vsStart)
        vsLeft <= eol ? vsWidth - 5'd1 : vsWidth;
      else if (eol && vsLeft != 5'd0)
        vsLeft <= vsLeft - 5'd1;
      hsync  <= (hsStart && hsWidth != 4'd0) || hsLeft != 4'd0;
      vsync  <= vsStart || vsLeft != 5'd0;
      de     <= deNow;
      cursor <= curNow;
      vma    <= addr;
      vra    <= rc[2:0];
    end
  end
endmodule

// File: tb/tb_crtc.sv
// tb_crtc: directed stimulus for crtc, checked every cycle against a position-based model plus literal spot checks.
module tb_crtc;
  localparam int FRAME = 202 * 64;

  logic clock = 1'b0;
  logic reset, cep, cs, rs, wr, rd;
  logic [7:0] d, q;
  logic hsync, vsync, de, cursor;
  logic [13:0] vma;
  logic [2:0] vra;

  int nChecks = 0;
  int nFails = 0;
  bit modelOn = 0;

  always #5 clock = ~clock;

  crtc dut (
    .clock(clock), .reset(reset), .cep(cep), .cs(cs), .rs(rs), .wr(wr), .rd(rd),
    .d(d), .q(q), .hsync(hsync), .vsync(vsync), .de(de), .cursor(cursor),
    .vma(vma), .vra(vra)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      if (nFails <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: screen position + register copy ----------------
  int mr [16];
  int mIdx, mHc, mRc, mVc, mLs, mLineBase, mLineTick, hsAge, vsLine, mField;
  bit mAdj;
  int eHs, eVs, eDe, eCur, eVma, eVra;
  int aNow, hsW, vsW, mode, gate;
  bit mEol, mDone, mLsHit;

  function automatic int maskOf(input int idx);
    case (idx)
      0, 1, 2, 3, 13, 15: return 255;
      4, 6, 7, 10:        return 127;
      5, 9, 11:           return 31;
      12, 14:             return 63;
      default:            return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      foreach (mr[i]) mr[i] = 0;
      mIdx = 0; mHc = 0; mRc = 0; mVc = 0; mAdj = 0; mLs = 0; mLineBase = 0; mLineTick = 0;
      hsAge = 1000; vsLine = 1000; mField = 0;
      eHs = 0; eVs = 0; eDe = 0; eCur = 0; eVma = 0; eVra = 0;
    end else begin
      if (cep) begin
        aNow = (mLineBase + mLineTick) % 16384;
        hsW = mr[3] % 16;
        vsW = (mr[3] / 16 == 0) ? 16 : mr[3] / 16;
        mode = (mr[10] / 32) % 4;
`ifdef CRTC_BLINK_EN
        gate = (mode == 0) ? 1 : (mode == 1) ? 0 : (mode == 2) ? (mField / 8) % 2 : (mField / 16) % 2;
`else
        gate = (mode != 1) ? 1 : 0;
`endif
        if (mHc == mr[2]) hsAge = 0;
        if (mHc == 0 && mRc == 0 && mVc == mr[7] && !mAdj) vsLine = 0;
        eHs  = (hsW != 0 && hsAge < hsW) ? 1 : 0;
        eVs  = (vsLine < vsW) ? 1 : 0;
        eDe  = (mHc < mr[1] && mVc < mr[6] && !mAdj) ? 1 : 0;
        eCur = (eDe == 1 && aNow == mr[14] * 256 + mr[15] && mRc >= mr[10] % 32 &&
                mRc <= mr[11] && gate == 1) ? 1 : 0;
        eVma = aNow;
        eVra = mRc % 8;
        if (hsAge < 1000) hsAge++;
        mEol = (mHc == mr[0]);
        mLsHit = (mHc == mr[1] && mRc == mr[9]);
        mDone = 0;
        if (mEol) begin
          if (vsLine < 1000) vsLine++;
          if (mAdj) begin
            if ((mRc + 1) % 32 == mr[5]) mDone = 1;
            else mRc = (mRc + 1) % 32;
          end else if (mRc == mr[9]) begin
            if (mVc == mr[4]) begin
              if (mr[5] != 0) begin mAdj = 1; mRc = 0; end
              else mDone = 1;
            end else begin
              mVc = (mVc + 1) % 128; mRc = 0;
            end
          end else begin
            mRc = (mRc + 1) % 32;
          end
        end
        if (mDone) begin
          mVc = 0; mRc = 0; mAdj = 0; mField = (mField + 1) % 32;
          mLs = (mr[12] * 256 + mr[13]) % 16384;
        end else if (mLsHit) begin
          mLs = aNow;
        end
        if (mEol) begin mLineBase = mLs; mLineTick = 0; end
        else mLineTick++;
        mHc = mEol ? 0 : (mHc + 1) % 256;
      end
      if (cs && wr) begin
        if (!rs) mIdx = d % 32;
        else if (mIdx < 16) mr[mIdx] = d & maskOf(mIdx);
      end
    end
  end

  always @(negedge clock) begin
    if (modelOn) begin
      chk("m_hsync", hsync, eHs);
      chk("m_vsync", vsync, eVs);
      chk("m_de", de, eDe);
      chk("m_cursor", cursor, eCur);
      chk("m_vma", vma, eVma);
      chk("m_vra", vra, eVra);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    cep = 1'b1;
    @(posedge clock); #1;
    cep = 1'b0;
  endtask

  task automatic idle(input int n);
    cep = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic tickWr(input logic rsv, input logic [7:0] dv);
    cs = 1'b1; wr = 1'b1; rs = rsv; d = dv; cep = 1'b1;
    @(posedge clock); #1;
    cs = 1'b0; wr = 1'b0; cep = 1'b0;
  endtask

  task automatic wrReg(input logic [7:0] idx, input logic [7:0] val);
    cs = 1'b1; wr = 1'b1; rs = 1'b0; d = idx;
    @(posedge clock); #1;
    rs = 1'b1; d = val;
    @(posedge clock); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rdReg(input logic [7:0] idx, output logic [7:0] v);
    cs = 1'b1; wr = 1'b1; rs = 1'b0; d = idx;
    @(posedge clock); #1;
    wr = 1'b0; rd = 1'b1; rs = 1'b1;
    #1 v = q;
    rd = 1'b0; cs = 1'b0;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_cursor"}, cursor, 0);
    chk({tag, "_vma"}, vma, 0);
    chk({tag, "_vra"}, vra, 0);
  endtask

  int cfgIdx [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
  int cfgVal [15] = '{63, 40, 48, 8'h34, 24, 2, 25, 20, 7, 8'h06, 7, 8'h01, 8'h00, 8'h01, 8'h05};

  initial begin
    logic [7:0] v;
    int hsRise, hsHigh, deHigh, vsHigh, curHigh, s;
    bit prevHs;
    reset = 1'b1; cep = 1'b0; cs = 1'b0; rs = 1'b0; wr = 1'b0; rd = 1'b0; d = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    modelOn = 1;
    chkAllZero("reset");
    reset = 1'b0;

    // register file access
    wrReg(8'hEE, 8'h3F); rdReg(8'd14, v); chk("rd_r14", v, 8'h3F);
    wrReg(8'd15, 8'hA5); rdReg(8'd15, v); chk("rd_r15", v, 8'hA5);
    wrReg(8'd2, 8'd48);  rdReg(8'd2, v);  chk("rd_r2_zero", v, 8'h00);
    wrReg(8'd14, 8'hFF); rdReg(8'd14, v); chk("rd_r14_mask", v, 8'h3F);
    wrReg(8'd20, 8'h55); rdReg(8'd14, v); chk("idx20_r14", v, 8'h3F);
    rdReg(8'd15, v); chk("idx20_r15", v, 8'hA5);
    rdReg(8'd20, v); chk("rd_idx20", v, 8'h00);
    cs = 1'b1; rd = 1'b1; rs = 1'b0; #1 chk("rd_addr_port", q, 8'h00);
    cs = 1'b0; rd = 1'b0;

    foreach (cfgIdx[i]) wrReg(8'(cfgIdx[i]), 8'(cfgVal[i]));

    // frame 1: start address still 0 until the first frame end
    hsRise = 0; hsHigh = 0; deHigh = 0; vsHigh = 0; prevHs = 0;
    for (int p = 0; p < FRAME; p++) begin
      tick();
      if (hsync && !prevHs) hsRise++;
      prevHs = hsync;
      hsHigh += int'(hsync); deHigh += int'(de); vsHigh += int'(vsync);
      case (p)
        0:     chk("f1_vma0", vma, 14'h0000);
        47:    chk("hs_before", hsync, 0);
        48:    chk("hs_first", hsync, 1);
        51:    chk("hs_last", hsync, 1);
        52:    chk("hs_after", hsync, 0);
        10239: chk("vs_before", vsync, 0);
        10240: chk("vs_first", vsync, 1);
        10431: chk("vs_last", vsync, 1);
        10432: chk("vs_after", vsync, 0);
        default: ;
      endcase
    end
    chk("frame_lines", hsRise, 202);
    chk("frame_hs_ticks", hsHigh, 808);
    chk("frame_de_ticks", deHigh, 8000);
    chk("frame_vs_ticks", vsHigh, 192);

    // frame 2: start address 0x0100, cep with idle gaps early on
    curHigh = 0;
    for (int p = FRAME; p < 2 * FRAME; p++) begin
      if (p < FRAME + 1000) idle($urandom_range(0, 2));
      tick();
      curHigh += int'(cursor);
      case (p - FRAME)
        0:       chk("f2_vma0", vma, 14'h0100);
        192:     chk("f2_vra3", vra, 3);
        6*64+5:  chk("cur_rc6", cursor, 1);
        7*64+5:  chk("cur_rc7", cursor, 1);
        511:     begin chk("row0_end_vma", vma, 14'h013F); chk("row0_end_vra", vra, 7); end
        512:     begin chk("row1_vma", vma, 14'h0128); chk("row1_vra", vra, 0); end
        default: ;
      endcase
    end
    chk("f2_cursor_ticks", curHigh, 2);

    // frame 3: lower R0 to 10 while hc=30 -> free-run to 255, wrap, then 11-cep lines
    s = 2 * FRAME;
    for (int p = s; p < s + 29; p++) tick();
    tickWr(1'b0, 8'd0);
    tickWr(1'b1, 8'd10);
    for (int p = s + 31; p <= s + 300; p++) begin
      tick();
      case (p - s)
        266: begin chk("wrap_last_vma", vma, 14'h020A); chk("wrap_last_vra", vra, 0); end
        267: begin chk("short1_vma", vma, 14'h0100); chk("short1_vra", vra, 1); end
        277: begin chk("short1_end_vma", vma, 14'h010A); chk("short1_end_vra", vra, 1); end
        278: begin chk("short2_vma", vma, 14'h0100); chk("short2_vra", vra, 2); end
        default: ;
      endcase
    end

    // reset mid-frame
    reset = 1'b1; cep = 1'b1;
    @(posedge clock); #1;
    chkAllZero("midreset");
    reset = 1'b0; cep = 1'b0;
    rdReg(8'd15, v); chk("midreset_r15", v, 8'h00);
    tick();
    chk("zero_regs_vsync", vsync, 1);
    chk("zero_regs_hsync", hsync, 0);
    chk("zero_regs_de", de, 0);
    chk("zero_regs_vma", vma, 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
